// File: rtl/cpu_pkg.sv
// Shared CPU definitions: MDU op encoding, MDU state enum and ALU control codes.
package cpu_pkg;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MFHI  = 3'd5;
    localparam logic [2:0] MDU_MFLO  = 3'd6;
    localparam logic [2:0] MDU_RSVD  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    // Bit 3 only distinguishes sra from srl; the other ops ignore it.
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    function automatic logic is_mdu_start(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic uses_mdu(input logic [2:0] op);
        return (op != MDU_NONE) && (op != MDU_RSVD);
    endfunction

endpackage

// File: rtl/pipe_exe_mdu_if.sv
// ID/EXE-side bundle of the EXE stage: decoded controls and operands in, results out.
interface pipe_exe_mdu_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RN_W  = 5,
    parameter int unsigned SA_W  = 5
);
    logic             e_valid;
    logic [3:0]       ealuc;
    logic             ealuimm;
    logic             eshift;
    logic             ejal;
    logic [2:0]       emdu_op;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    logic [WIDTH-1:0] eimm;
    logic [SA_W-1:0]  esa;
    logic [WIDTH-1:0] epc4;
    logic [RN_W-1:0]  ern0;
    logic [WIDTH-1:0] ealu;
    logic [RN_W-1:0]  ern;
    logic             ezero;
    logic             estall;
    logic             mdu_busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output e_valid, ealuc, ealuimm, eshift, ejal, emdu_op, ea, eb, eimm, esa, epc4, ern0,
        input  ealu, ern, ezero, estall, mdu_busy, hi, lo
    );

    modport slave (
        input  e_valid, ealuc, ealuimm, eshift, ejal, emdu_op, ea, eb, eimm, esa, epc4, ern0,
        output ealu, ern, ezero, estall, mdu_busy, hi, lo
    );
endinterface

// File: rtl/alu.sv
// Single-cycle ALU; shifts take their amount from operand a and shift operand b.
module alu
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluc,
    output logic [WIDTH-1:0] r
);
    localparam int unsigned SH_W = $clog2(WIDTH);
    localparam int unsigned HALF = WIDTH / 2;

    logic [SH_W-1:0] sh;
    assign sh = a[SH_W-1:0];

    always_comb begin
        r = '0;
        case (aluc[2:0])
            ALU_ADD[2:0]: r = a + b;
            ALU_SUB[2:0]: r = a - b;
            ALU_AND[2:0]: r = a & b;
            ALU_OR[2:0]:  r = a | b;
            ALU_XOR[2:0]: r = a ^ b;
            ALU_LUI[2:0]: r = {b[HALF-1:0], {HALF{1'b0}}};
            ALU_SLL[2:0]: r = b << sh;
            ALU_SRL[2:0]: begin
                if (aluc[3]) r = $signed(b) >>> sh;
                else         r = b >> sh;
            end
            default:      r = '0;
        endcase
    end
endmodule

// File: rtl/mux2x32.sv
// Two-way operand multiplexer.
module mux2x32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);
    assign y = s ? a1 : a0;
endmodule

// File: rtl/pipe_exe_mdu_mdu_iter.sv
// Iterative radix-2 multiply / restoring divide on magnitudes, with sign fix into HI/LO.
module mdu_iter
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    mdu_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] ph;
    logic [WIDTH-1:0] pl;
    logic             neg_lo;
    logic             neg_hi;
    logic             dz;

    logic             signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum, div_trial;
    logic [WIDTH-1:0] mul_ph, mul_pl, div_ph, div_pl;
    logic             div_ok;
    logic [2*WIDTH-1:0] mul_prod;

    assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    assign abs_a     = a_neg ? -a : a;
    assign abs_b     = b_neg ? -b : b;

    // One shift-add step: ph accumulates, pl shifts the multiplier out and the product in.
    assign mul_sum   = {1'b0, ph} + (pl[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    assign mul_ph    = mul_sum[WIDTH:1];
    assign mul_pl    = {mul_sum[0], pl[WIDTH-1:1]};
    assign mul_prod  = {mul_ph, mul_pl};

    // One restoring step: ph is the partial remainder, pl shifts the dividend out and quotient in.
    assign div_trial = {ph, pl[WIDTH-1]} - {1'b0, opb};
    assign div_ok    = ~div_trial[WIDTH];
    assign div_ph    = div_ok ? div_trial[WIDTH-1:0] : {ph[WIDTH-2:0], pl[WIDTH-1]};
    assign div_pl    = {pl[WIDTH-2:0], div_ok};

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            opb    <= '0;
            ph     <= '0;
            pl     <= '0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ((op == MDU_MULT) || (op == MDU_MULTU)) ? ST_MUL : ST_DIV;
                        cnt    <= CNT_W'(WIDTH);
                        opb    <= abs_b;
                        ph     <= '0;
                        pl     <= abs_a;
                        neg_lo <= a_neg ^ b_neg;
                        neg_hi <= a_neg;
                        dz     <= (b == '0);
                    end
                end
                ST_MUL: begin
                    ph  <= mul_ph;
                    pl  <= mul_pl;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        {hi, lo} <= neg_lo ? -mul_prod : mul_prod;
                        state    <= ST_IDLE;
                    end
                end
                ST_DIV: begin
                    ph  <= div_ph;
                    pl  <= div_pl;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        // A zero divisor leaves |dividend| in the remainder; the quotient is forced.
                        lo    <= dz ? '1 : (neg_lo ? -div_pl : div_pl);
                        hi    <= neg_hi ? -div_ph : div_ph;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/pipe_exe_mdu.sv
// EXE stage: single-cycle ALU path plus iterative MDU with HI/LO and dependency stall.
module pipe_exe_mdu
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RN_W  = 5,
    parameter int unsigned SA_W  = 5
) (
    input logic           clock,
    input logic           resetn,
    pipe_exe_mdu_if.slave bus
);
    logic [WIDTH-1:0] sa_ext, alu_a, alu_b, alu_r, hi, lo, ealu;
    logic             busy;

    assign sa_ext = WIDTH'(bus.esa);

    mux2x32 #(.WIDTH(WIDTH)) u_mux_a (.a0(bus.ea), .a1(sa_ext),   .s(bus.eshift),  .y(alu_a));
    mux2x32 #(.WIDTH(WIDTH)) u_mux_b (.a0(bus.eb), .a1(bus.eimm), .s(bus.ealuimm), .y(alu_b));

    alu #(.WIDTH(WIDTH)) u_alu (.a(alu_a), .b(alu_b), .aluc(bus.ealuc), .r(alu_r));

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clock  (clock),
        .resetn (resetn),
        .start  (bus.e_valid && is_mdu_start(bus.emdu_op)),
        .op     (bus.emdu_op),
        .a      (bus.ea),
        .b      (bus.eb),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    // Link value wins over HI/LO moves, which win over the ALU result.
    always_comb begin
        ealu = alu_r;
        if (bus.ejal)                     ealu = bus.epc4;
        else if (bus.emdu_op == MDU_MFHI) ealu = hi;
        else if (bus.emdu_op == MDU_MFLO) ealu = lo;
    end

    assign bus.ealu     = ealu;
    assign bus.ern      = bus.ern0 | {RN_W{bus.ejal}};
    assign bus.ezero    = (alu_r == '0);
    assign bus.estall   = bus.e_valid && busy && uses_mdu(bus.emdu_op);
    assign bus.mdu_busy = busy;
    assign bus.hi       = hi;
    assign bus.lo       = lo;
endmodule

// File: tb/tb_pipe_exe_mdu.sv
// Self-checking bench for pipe_exe_mdu: directed literals plus random stream vs. arithmetic model.
`timescale 1ns/1ps
module tb_pipe_exe_mdu;
    import cpu_pkg::*;

    localparam int unsigned W = 32;

    typedef struct {
        logic        v;
        logic [3:0]  aluc;
        logic        imm;
        logic        sh;
        logic        jal;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] im;
        logic [4:0]  sa;
        logic [31:0] pc4;
        logic [4:0]  rn;
    } instr_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    bit   chk_en = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    pipe_exe_mdu_if #(.WIDTH(W), .RN_W(5), .SA_W(5)) bus ();
    pipe_exe_mdu #(.WIDTH(W), .RN_W(5), .SA_W(5)) dut (.clock(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        case (c)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_LUI: return {b[15:0], 16'h0000};
            ALU_SLL: return b << a[4:0];
            ALU_SRL: return b >> a[4:0];
            ALU_SRA: return 32'($signed(b) >>> a[4:0]);
            default: return 32'h0;
        endcase
    endfunction

    // Returns {hi, lo}.
    function automatic logic [63:0] mdu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        int     q, r;
        case (op)
            MDU_MULT: begin
                x = longint'($signed(a));
                y = longint'($signed(b));
                return 64'(x * y);
            end
            MDU_MULTU: return {32'h0, a} * {32'h0, b};
            MDU_DIV: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {32'(r), 32'(q)};
            end
            MDU_DIVU: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (bus.e_valid && (bus.emdu_op inside {[3'd1:3'd4]})) begin
            {p_hi, p_lo} = mdu_ref(bus.emdu_op, bus.ea, bus.eb);
            m_left = W;
        end
    end

    // Every cycle: all outputs against the model.
    always @(negedge clk) begin
        logic [31:0] oa, ob, r, e_alu;
        logic        e_stall;
        if (chk_en) begin
            oa = bus.eshift ? {27'h0, bus.esa} : bus.ea;
            ob = bus.ealuimm ? bus.eimm : bus.eb;
            r  = alu_ref(oa, ob, bus.ealuc);
            if (bus.ejal)                     e_alu = bus.epc4;
            else if (bus.emdu_op == MDU_MFHI) e_alu = m_hi;
            else if (bus.emdu_op == MDU_MFLO) e_alu = m_lo;
            else                              e_alu = r;
            e_stall = bus.e_valid && (m_left > 0) && (bus.emdu_op inside {[3'd1:3'd6]});
            chk("ealu",     64'(bus.ealu),     64'(e_alu));
            chk("ern",      64'(bus.ern),      64'(bus.ern0 | {5{bus.ejal}}));
            chk("ezero",    64'(bus.ezero),    64'(r == 32'h0));
            chk("estall",   64'(bus.estall),   64'(e_stall));
            chk("mdu_busy", 64'(bus.mdu_busy), 64'(m_left > 0));
            chk("hi",       64'(bus.hi),       64'(m_hi));
            chk("lo",       64'(bus.lo),       64'(m_lo));
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic instr_t nop();
        instr_t i;
        i = '{v: 1'b0, aluc: ALU_ADD, imm: 1'b0, sh: 1'b0, jal: 1'b0, op: MDU_NONE,
              a: 32'h0, b: 32'h0, im: 32'h0, sa: 5'h0, pc4: 32'h0, rn: 5'h0};
        return i;
    endfunction

    function automatic instr_t mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        instr_t i;
        i    = nop();
        i.v  = 1'b1;
        i.op = op;
        i.a  = a;
        i.b  = b;
        return i;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] sp [6];
        sp = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0007};
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    function automatic instr_t rand_instr();
        instr_t      i;
        logic [3:0]  codes [9];
        codes  = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA};
        i.v    = ($urandom_range(0, 9) != 0);
        i.aluc = codes[$urandom_range(0, 8)];
        i.imm  = 1'($urandom_range(0, 1));
        i.sh   = 1'($urandom_range(0, 1));
        i.jal  = ($urandom_range(0, 9) == 0);
        i.op   = ($urandom_range(0, 9) < 6) ? MDU_NONE : 3'($urandom_range(1, 7));
        i.a    = rand_word();
        i.b    = rand_word();
        i.im   = rand_word();
        i.sa   = 5'($urandom);
        i.pc4  = $urandom;
        i.rn   = 5'($urandom);
        return i;
    endfunction

    task automatic apply(input instr_t i);
        bus.e_valid = i.v;   bus.ealuc = i.aluc; bus.ealuimm = i.imm; bus.eshift = i.sh;
        bus.ejal    = i.jal; bus.emdu_op = i.op; bus.ea = i.a;        bus.eb = i.b;
        bus.eimm    = i.im;  bus.esa = i.sa;     bus.epc4 = i.pc4;    bus.ern0 = i.rn;
    endtask

    // Hold the instruction in EXE while stalled; report stall cycles and ealu of the advancing cycle.
    task automatic issue(input instr_t i, output int nst, output logic [31:0] seen);
        bit done;
        apply(i);
        nst  = 0;
        seen = '0;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (!bus.estall) begin
                seen = bus.ealu;
                done = 1'b1;
            end else begin
                nst++;
            end
        end
        if (!done) begin
            n_assert++;
            n_fail++;
            $display("FAIL issue_timeout: stalled %0d cycles, limit 100", nst);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int nbusy);
        bit done;
        nbusy = 0;
        done  = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (!bus.mdu_busy) done = 1'b1;
            else               nbusy++;
        end
        if (!done) begin
            n_assert++;
            n_fail++;
            $display("FAIL idle_timeout: busy %0d cycles, limit 200", nbusy);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        instr_t      i;
        int          nst, nb;
        logic [31:0] seen;
        logic [31:0] da [4], db [4], elo [4], ehi [4];
        logic [2:0]  dop [4];

        apply(nop());
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_busy",  64'(bus.mdu_busy), 64'h0);
        chk("rst_hi",    64'(bus.hi),       64'h0);
        chk("rst_lo",    64'(bus.lo),       64'h0);
        chk("rst_stall", 64'(bus.estall),   64'h0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // jal link
        i = nop(); i.v = 1'b1; i.jal = 1'b1; i.pc4 = 32'h0040_0010; i.rn = 5'd5;
        apply(i);
        @(negedge clk);
        chk("jal_ern",   64'(bus.ern),    64'd31);
        chk("jal_ealu",  64'(bus.ealu),   64'h0040_0010);
        chk("jal_stall", 64'(bus.estall), 64'h0);
        @(posedge clk);
        #1;

        // signed multiply with busy-length check
        issue(mdu(MDU_MULT, 32'hFFFF_FFFD, 32'd5), nst, seen);
        chk("mult_accept_stall", 64'(nst), 64'd0);
        apply(nop());
        wait_idle(nb);
        chk("mult_busy_cycles", 64'(nb), 64'd32);
        chk("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(bus.lo), 64'hFFFF_FFF1);
        @(posedge clk);
        #1;

        // divide table: divu, signed div, divide by zero, MIN / -1
        dop = '{MDU_DIVU, MDU_DIV, MDU_DIV, MDU_DIV};
        da  = '{32'd100, 32'hFFFF_FFF9, 32'h1234_5678, 32'h8000_0000};
        db  = '{32'd7,   32'd2,         32'h0,         32'hFFFF_FFFF};
        elo = '{32'h0000_000E, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        ehi = '{32'h0000_0002, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000};
        for (int k = 0; k < 4; k++) begin
            issue(mdu(dop[k], da[k], db[k]), nst, seen);
            apply(nop());
            wait_idle(nb);
            chk($sformatf("div%0d_busy_cycles", k), 64'(nb), 64'd32);
            chk($sformatf("div%0d_lo", k), 64'(bus.lo), 64'(elo[k]));
            chk($sformatf("div%0d_hi", k), 64'(bus.hi), 64'(ehi[k]));
            @(posedge clk);
            #1;
        end

        // mfhi three cycles behind a mult stalls until the result lands
        issue(mdu(MDU_MULT, 32'h0001_0000, 32'h0003_0000), nst, seen);
        issue(nop(), nst, seen);
        issue(nop(), nst, seen);
        i = mdu(MDU_MFHI, 32'h0, 32'h0); i.rn = 5'd3;
        issue(i, nst, seen);
        chk("mfhi_stall_cycles", 64'(nst), 64'd30);
        chk("mfhi_value",        64'(seen), 64'h3);

        // independent add flows under a busy MDU
        issue(mdu(MDU_MULT, 32'd7, 32'd9), nst, seen);
        i = nop(); i.v = 1'b1; i.a = 32'd5; i.b = 32'd7; i.rn = 5'd8;
        issue(i, nst, seen);
        chk("add_under_busy_stall", 64'(nst), 64'd0);
        chk("add_under_busy_ealu",  64'(seen), 64'd12);
        apply(nop());
        wait_idle(nb);
        chk("mult7x9_lo", 64'(bus.lo), 64'd63);
        @(posedge clk);
        #1;

        // reset in the middle of a divide, with a dependent mfhi stalled behind it
        issue(mdu(MDU_DIV, 32'h7FFF_FFFF, 32'd3), nst, seen);
        issue(nop(), nst, seen);
        apply(mdu(MDU_MFHI, 32'h0, 32'h0));
        @(negedge clk);
        chk("pre_rst_stall", 64'(bus.estall), 64'h1);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_busy",  64'(bus.mdu_busy), 64'h0);
        chk("midrst_hi",    64'(bus.hi),       64'h0);
        chk("midrst_lo",    64'(bus.lo),       64'h0);
        chk("midrst_stall", 64'(bus.estall),   64'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        apply(nop());
        @(posedge clk);
        #1;

        // random stream against the model
        for (int n = 0; n < 300; n++) begin
            issue(rand_instr(), nst, seen);
        end
        apply(nop());
        wait_idle(nb);
        @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
